load_store_unit: RTL and testbench

//  Memory stage following the ALU in the non-pipelined CPU: takes the ALU result as effective address, runs
//  one load or store per request over a req/ack data-memory bus, and returns the aligned, extended load word.

---
 rtl/lsu_mem_if.sv | 13 +
 rtl/load_store_unit.sv | 152 +++++++++++++++
 tb/tb_load_store_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_if.sv
// Data-memory request/acknowledge bus between the load/store unit (master) and data memory (slave).
interface lsu_mem_if #(parameter int WIDTH = 32) ();
  logic             m_req;
  logic             m_we;
  logic [WIDTH-1:0] m_addr;
  logic [3:0]       m_be;
  logic [WIDTH-1:0] m_wdata;
  logic             m_ack;
  logic [WIDTH-1:0] m_rdata;

  modport master (output m_req, m_we, m_addr, m_be, m_wdata, input m_ack, m_rdata);
  modport slave  (input m_req, m_we, m_addr, m_be, m_wdata, output m_ack, m_rdata);
endinterface

// File: rtl/load_store_unit.sv
// Memory stage: one aligned load/store per start over a req/ack bus, returns the extended load word.
// Optional LSU_TIMEOUT_EN: bus_err after TIMEOUT unacknowledged REQ cycles.
module load_store_unit #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [1:0]       size,
  input  logic             unsigned_ld,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rdata,
  output logic             misaligned,
  output logic             bus_err,
  lsu_mem_if.master        mem
);
  localparam int NUM_LANES = WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
  state_t state, state_nxt;

  logic                         m_req, m_we;
  logic [WIDTH-1:0]             m_addr, m_wdata;
  logic [NUM_LANES-1:0]         m_be;
  logic [1:0]                   lat_size, lat_lo;
  logic                         lat_uns;
  logic                         reject, tmo_hit;
  logic [NUM_LANES-1:0]         be_nxt;
  logic [NUM_LANES-1:0][7:0]    wd_lane;
  logic [7:0]                   byte_sel;
  logic [15:0]                  half_sel;
  logic [WIDTH-1:0]             ld_ext;

  assign mem.m_req   = m_req;
  assign mem.m_we    = m_we;
  assign mem.m_addr  = m_addr;
  assign mem.m_be    = m_be;
  assign mem.m_wdata = m_wdata;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Illegal or misaligned requests complete without touching the bus.
  assign reject = (size == 2'b11) || (mem_read == mem_write) ||
                  (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);

  always_comb begin
    be_nxt = '1;
    case (size)
      2'b00:   be_nxt = 4'(4'b0001 << addr[1:0]);
      2'b01:   be_nxt = 4'(4'b0011 << addr[1:0]);
      default: be_nxt = '1;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign wd_lane[i] = (size == 2'b00) ? wdata[7:0] :
                        (size == 2'b01) ? wdata[8*(i%2) +: 8] : wdata[8*i +: 8];
  end

  always_comb begin
    byte_sel = mem.m_rdata[{lat_lo, 3'b000} +: 8];
    half_sel = mem.m_rdata[{lat_lo[1], 4'b0000} +: 16];
    ld_ext   = mem.m_rdata;
    case (lat_size)
      2'b00:   ld_ext = {{(WIDTH-8){~lat_uns & byte_sel[7]}}, byte_sel};
      2'b01:   ld_ext = {{(WIDTH-16){~lat_uns & half_sel[15]}}, half_sel};
      default: ld_ext = mem.m_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] tmo_cnt;

  // Limit hit on the TIMEOUT-th unacknowledged REQ cycle; an ack in that cycle still wins.
  assign tmo_hit = (tmo_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst)                           tmo_cnt <= '0;
    else if (state == S_IDLE)          tmo_cnt <= '0;
    else if (state == S_REQ && !mem.m_ack) tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = reject ? S_DONE : S_REQ;
      S_REQ:  if (mem.m_ack || tmo_hit) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_be       <= '0;
      m_wdata    <= '0;
      rdata      <= '0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      lat_size   <= 2'b00;
      lat_lo     <= 2'b00;
      lat_uns    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (start) begin
          if (reject) begin
            misaligned <= 1'b1;
          end else begin
            m_req    <= 1'b1;
            m_we     <= mem_write;
            m_addr   <= {addr[WIDTH-1:2], 2'b00};
            m_be     <= be_nxt;
            m_wdata  <= wd_lane;
            lat_size <= size;
            lat_lo   <= addr[1:0];
            lat_uns  <= unsigned_ld;
          end
        end
        S_REQ: begin
          if (mem.m_ack) begin
            m_req <= 1'b0;
            if (!m_we) rdata <= ld_ext;
          end else if (tmo_hit) begin
            m_req   <= 1'b0;
            bus_err <= 1'b1;
          end
        end
        S_DONE: begin
          misaligned <= 1'b0;
          bus_err    <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads/stores, lane select/extension, rejects, reset mid-access.
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst, start, mem_read, mem_write, unsigned_ld;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy, done, misaligned, bus_err;
  logic [31:0] rdata;
  int          pass_cnt = 0;
  int          total = 0;

  lsu_mem_if #(.WIDTH(32)) bus ();

  load_store_unit #(.WIDTH(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_read(mem_read), .mem_write(mem_write),
    .size(size), .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .misaligned(misaligned), .bus_err(bus_err),
    .mem(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Issue one start; afterwards scramble the request inputs to prove they were latched.
  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    mem_read = rd; mem_write = wr; size = sz; unsigned_ld = uns; addr = a; wdata = wd;
    start = 1'b1;
    step();
    start = 1'b0;
    mem_read = ~rd; mem_write = ~wr; size = ~sz; unsigned_ld = ~uns; addr = ~a; wdata = ~wd;
  endtask

  // From the first REQ cycle: wait 'waits' cycles, then ack with 'rd'; ends on the done cycle.
  task automatic ack_after(input int waits, input logic [31:0] rd);
    for (int i = 0; i < waits; i++) begin
      step();
      chk("wait_m_req", 32'(bus.m_req), 32'd1);
      chk("wait_done", 32'(done), 32'd0);
    end
    bus.m_ack = 1'b1; bus.m_rdata = rd;
    step();
    bus.m_ack = 1'b0; bus.m_rdata = 32'h0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0; size = 2'b00;
    unsigned_ld = 1'b0; addr = 32'h0; wdata = 32'h0; bus.m_ack = 1'b0; bus.m_rdata = 32'h0;
    step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_misaligned", 32'(misaligned), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_m_req", 32'(bus.m_req), 32'd0);
    chk("rst_m_we", 32'(bus.m_we), 32'd0);
    chk("rst_m_addr", bus.m_addr, 32'h0);
    chk("rst_m_be", 32'(bus.m_be), 32'h0);
    chk("rst_m_wdata", bus.m_wdata, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    rst = 1'b0;
    step();

    // lw 0x100, two wait cycles; a second start while busy must be ignored
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
    chk("lw_m_req", 32'(bus.m_req), 32'd1);
    chk("lw_busy", 32'(busy), 32'd1);
    chk("lw_m_we", 32'(bus.m_we), 32'd0);
    chk("lw_m_addr", bus.m_addr, 32'h0000_0100);
    chk("lw_m_be", 32'(bus.m_be), 32'hF);
    mem_read = 1'b1; mem_write = 1'b0; size = 2'b10; addr = 32'h0000_0800; start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_start_m_addr", bus.m_addr, 32'h0000_0100);
    ack_after(1, 32'hDEAD_BEEF);
    chk("lw_done", 32'(done), 32'd1);
    chk("lw_rdata", rdata, 32'hDEAD_BEEF);
    chk("lw_misaligned", 32'(misaligned), 32'd0);
    chk("lw_m_req_drop", 32'(bus.m_req), 32'd0);
    step();
    chk("lw_done_clear", 32'(done), 32'd0);
    chk("lw_busy_clear", 32'(busy), 32'd0);
    chk("lw_rdata_hold", rdata, 32'hDEAD_BEEF);

    // lb signed / lbu at 0x103, ack in first REQ cycle
    issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0);
    chk("lb_m_be", 32'(bus.m_be), 32'h8);
    chk("lb_m_addr", bus.m_addr, 32'h0000_0100);
    ack_after(0, 32'h80FF_1234);
    chk("lb_done", 32'(done), 32'd1);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    step();
    issue(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0);
    ack_after(0, 32'h80FF_1234);
    chk("lbu_rdata", rdata, 32'h0000_0080);
    step();

    // lh signed at 0x102 takes upper half
    issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0);
    chk("lh_m_be", 32'(bus.m_be), 32'hC);
    ack_after(0, 32'h8001_0000);
    chk("lh_rdata", rdata, 32'hFFFF_8001);
    step();

    // sh 0x202: store leaves rdata unchanged
    issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD);
    chk("sh_m_we", 32'(bus.m_we), 32'd1);
    chk("sh_m_addr", bus.m_addr, 32'h0000_0200);
    chk("sh_m_be", 32'(bus.m_be), 32'hC);
    chk("sh_m_wdata", bus.m_wdata, 32'hABCD_ABCD);
    ack_after(0, 32'h1111_1111);
    chk("sh_done", 32'(done), 32'd1);
    chk("sh_rdata_keep", rdata, 32'hFFFF_8001);
    step();

    // lh 0x201 misaligned: done next cycle, no bus request
    issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0201, 32'h0);
    chk("lh_mis_done", 32'(done), 32'd1);
    chk("lh_mis_flag", 32'(misaligned), 32'd1);
    chk("lh_mis_m_req", 32'(bus.m_req), 32'd0);
    chk("lh_mis_busy", 32'(busy), 32'd1);
    step();
    chk("lh_mis_clear", 32'(misaligned), 32'd0);
    chk("lh_mis_idle", 32'(busy), 32'd0);

    // sb 0x11
    issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_005A);
    chk("sb_m_be", 32'(bus.m_be), 32'h2);
    chk("sb_m_wdata", bus.m_wdata, 32'h5A5A_5A5A);
    chk("sb_m_addr", bus.m_addr, 32'h0000_0010);
    ack_after(0, 32'h0);
    chk("sb_done", 32'(done), 32'd1);
    step();

    // both mem_read and mem_write -> illegal
    issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h0);
    chk("rw_mis_done", 32'(done), 32'd1);
    chk("rw_mis_flag", 32'(misaligned), 32'd1);
    chk("rw_mis_m_req", 32'(bus.m_req), 32'd0);
    step();

    // size 11 -> illegal
    issue(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0040, 32'h0);
    chk("sz11_mis_flag", 32'(misaligned), 32'd1);
    step();

`ifdef LSU_TIMEOUT_EN
    // no ack: four REQ cycles then bus error
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("tmo_m_req_held", 32'(bus.m_req), 32'd1);
    end
    step();
    chk("tmo_done", 32'(done), 32'd1);
    chk("tmo_bus_err", 32'(bus_err), 32'd1);
    chk("tmo_m_req_drop", 32'(bus.m_req), 32'd0);
    chk("tmo_rdata_keep", rdata, 32'hFFFF_8001);
    step();
    chk("tmo_bus_err_clear", 32'(bus_err), 32'd0);
`else
    // no ack: request holds indefinitely; reset abandons it below
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0);
    repeat (10) step();
    chk("noack_m_req_held", 32'(bus.m_req), 32'd1);
    chk("noack_bus_err", 32'(bus_err), 32'd0);
    chk("noack_done", 32'(done), 32'd0);
    rst = 1'b1; step(); rst = 1'b0; step();
`endif

    // reset asserted in second REQ cycle
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstreq_m_req", 32'(bus.m_req), 32'd0);
    chk("rstreq_busy", 32'(busy), 32'd0);
    chk("rstreq_done", 32'(done), 32'd0);
    bus.m_ack = 1'b1; bus.m_rdata = 32'hBAD0_BAD0;
    step();
    bus.m_ack = 1'b0;
    chk("stray_ack_done", 32'(done), 32'd0);
    chk("stray_ack_busy", 32'(busy), 32'd0);
    issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0);
    chk("post_rst_m_addr", bus.m_addr, 32'h0000_0004);
    ack_after(0, 32'h1234_5678);
    chk("post_rst_done", 32'(done), 32'd1);
    chk("post_rst_rdata", rdata, 32'h1234_5678);
    step();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
